// File: rtl/wb_csr_responder_pkg.sv
// Shared types and bus widths for the Wishbone CSR responder and its address decoder.
package pkg_wb_csr;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  // Request classes, in decode priority order after the window check.
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RW,
    CLS_RO,
    CLS_HOLE,
    CLS_BAD
  } cls_t;

endpackage

// File: rtl/wb_csr_responder_decode.sv
// Combinational window decoder: classifies a Wishbone address/direction and
// returns the 32-bit word index within the window.
module wb_csr_decode
  import pkg_wb_csr::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_5200,
  parameter int          DEPTH     = 512,
  parameter int          N_RW      = 8,
  parameter int          N_RO      = 8
) (
  input  logic [WB_DW-1:0] wb_adr,
  input  logic             wb_we,
  output cls_t             cls,
  output logic [29:0]      word_idx
);

  localparam logic [31:0] RW_END = 32'(N_RW);
  localparam logic [31:0] RO_END = 32'(N_RW + N_RO);

  logic [32:0] adr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;
  logic [31:0] offset;
  logic [31:0] idx_ext;
  logic        in_window;

  // The upper bound is 33 bits wide so a window ending at the top of the map
  // cannot wrap around and claim low addresses.
  always_comb begin
    adr_ext   = {1'b0, wb_adr};
    win_lo    = {1'b0, BASE_ADDR};
    win_hi    = win_lo + 33'(DEPTH);
    in_window = (adr_ext >= win_lo) && (adr_ext < win_hi);
    offset    = wb_adr - BASE_ADDR;
    idx_ext   = {2'b00, offset[31:2]};
    word_idx  = offset[31:2];
  end

  always_comb begin
    cls = CLS_NONE;
    if (!in_window) begin
      cls = CLS_NONE;
    end else if (offset[1:0] != 2'b00) begin
      cls = CLS_BAD;
    end else if (idx_ext < RW_END) begin
      cls = CLS_RW;
    end else if (idx_ext < RO_END) begin
      cls = wb_we ? CLS_BAD : CLS_RO;
    end else begin
      cls = wb_we ? CLS_BAD : CLS_HOLE;
    end
  end

endmodule

// File: rtl/wb_csr_responder.sv
// Wishbone classic slave endpoint for one address-map window: control registers,
// sampled status words, and single-cycle ack/err responses.
module wb_csr_responder
  import pkg_wb_csr::*;
#(
  parameter logic [31:0]          BASE_ADDR = 32'h8000_5200,
  parameter int                   DEPTH     = 512,
  parameter int                   N_RW      = 8,
  parameter int                   N_RO      = 8,
  parameter logic [N_RW*32-1:0]   RW_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [WB_DW-1:0]     wb_adr,
  input  logic [WB_DW-1:0]     wb_dat_w,
  input  logic [WB_SELW-1:0]   wb_sel,
  output logic                 wb_ack,
  output logic                 wb_err,
  output logic [WB_DW-1:0]     wb_dat_r,
  output logic [N_RW*32-1:0]   ctrl_o,
  output logic [N_RW-1:0]      wr_pulse_o,
  input  logic [N_RO*32-1:0]   status_i,
  output logic [N_RO-1:0]      rd_pulse_o
);

  // Handshake: wb_cyc & wb_stb is the request-valid. A request is accepted only
  // while in S_IDLE; the reply is one registered cycle of wb_ack or wb_err, with
  // no back-pressure. Requests presented during S_RESP are not accepted.

  state_t               state;
  state_t               state_nx;
  cls_t                 cls;
  logic [29:0]          word_idx;

  logic                 ack_q, ack_nx;
  logic                 err_q, err_nx;
  logic [WB_DW-1:0]     dat_q, dat_nx;
  logic [N_RW*32-1:0]   ctrl_q, ctrl_nx;
  logic [N_RW-1:0]      wr_q, wr_nx;
  logic [N_RO-1:0]      rd_q, rd_nx;

  wb_csr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .N_RW      (N_RW),
    .N_RO      (N_RO)
  ) u_decode (
    .wb_adr   (wb_adr),
    .wb_we    (wb_we),
    .cls      (cls),
    .word_idx (word_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      ctrl_q <= RW_RESET;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      state  <= state_nx;
      ack_q  <= ack_nx;
      err_q  <= err_nx;
      dat_q  <= dat_nx;
      ctrl_q <= ctrl_nx;
      wr_q   <= wr_nx;
      rd_q   <= rd_nx;
    end
  end

  // All side effects are committed at the accept edge, so the response cycle
  // only replays registered values and cannot be cancelled by wb_cyc dropping.
  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    dat_nx   = '0;
    ctrl_nx  = ctrl_q;
    wr_nx    = '0;
    rd_nx    = '0;
    case (state)
      S_IDLE: begin
        if (wb_cyc && wb_stb) begin
          if (cls != CLS_NONE) state_nx = S_RESP;
          case (cls)
            CLS_RW: begin
              ack_nx = 1'b1;
              for (int i = 0; i < N_RW; i++) begin
                if (word_idx == 30'(i)) begin
                  if (wb_we) begin
                    for (int b = 0; b < WB_SELW; b++) begin
                      if (wb_sel[b]) ctrl_nx[32*i + 8*b +: 8] = wb_dat_w[8*b +: 8];
                    end
                    wr_nx[i] = 1'b1;
                  end else begin
                    dat_nx = ctrl_q[32*i +: 32];
                  end
                end
              end
            end
            CLS_RO: begin
              ack_nx = 1'b1;
              for (int i = 0; i < N_RO; i++) begin
                if (word_idx == 30'(N_RW + i)) begin
                  dat_nx   = status_i[32*i +: 32];
                  rd_nx[i] = 1'b1;
                end
              end
            end
            CLS_HOLE: ack_nx = 1'b1;
            CLS_BAD:  err_nx = 1'b1;
            default:  ;
          endcase
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign wb_ack     = ack_q;
  assign wb_err     = err_q;
  assign wb_dat_r   = dat_q;
  assign ctrl_o     = ctrl_q;
  assign wr_pulse_o = wr_q;
  assign rd_pulse_o = rd_q;

endmodule
